// File: rtl/vga_timing_gen.sv
// Pixel divider, raster counters and sync/colour output stage for a VGA display.
// Define VGA_GEN_TICK_EN to build the frame counter that drives gen_tick.
module vga_timing_gen #(
   parameter int CLK_DIV        = 4,
   parameter int H_ACTIVE       = 640,
   parameter int H_FP           = 16,
   parameter int H_SYNC         = 96,
   parameter int H_BP           = 48,
   parameter int V_ACTIVE       = 480,
   parameter int V_FP           = 10,
   parameter int V_SYNC         = 2,
   parameter int V_BP           = 33,
   parameter bit SYNC_POL       = 1'b0,
   parameter int FRAMES_PER_GEN = 30
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] rgb_in,
   output logic        pix_en,
   output logic [10:0] x,
   output logic [10:0] y,
   output logic        hsync,
   output logic        vsync,
   output logic [11:0] rgb_out,
   output logic        frame_start,
   output logic        gen_tick
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT_END = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT_END = 10'(V_ACTIVE);
   localparam logic [9:0] HS_FIRST  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic SYNC_ON  = SYNC_POL;
   localparam logic SYNC_OFF = ~SYNC_POL;

   if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("vga_timing_gen: CLK_DIV must be at least 2");
   end
   if (FRAMES_PER_GEN < 1) begin : g_bad_frames
      $error("vga_timing_gen: FRAMES_PER_GEN must be at least 1");
   end

   logic [DIV_W-1:0] divider;
   logic [9:0]       h_cnt;
   logic [9:0]       v_cnt;
   logic [9:0]       h_next;
   logic [9:0]       v_next;
   logic             h_wrap;
   logic             v_wrap;
   logic             h_act_next;
   logic             v_act_next;
   logic             hs_next;
   logic             vs_next;
   logic             hs_q;
   logic             vs_q;
   logic             pix_active;

   // Next raster position and its decoded flags, registered into x/y on pix_en.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      h_wrap = (h_cnt == H_LAST);
      v_wrap = (v_cnt == V_LAST);
      h_next = h_wrap ? 10'd0 : h_cnt + 10'd1;
      v_next = v_cnt;
      if (h_wrap) begin
         v_next = v_wrap ? 10'd0 : v_cnt + 10'd1;
      end
      h_act_next = (h_next < H_ACT_END);
      v_act_next = (v_next < V_ACT_END);
      hs_next    = (h_next >= HS_FIRST) && (h_next <= HS_LAST);
      vs_next    = (v_next >= VS_FIRST) && (v_next <= VS_LAST);
   end

   // Active flags of the pixel presented on x/y, i.e. the one rgb_in currently describes.
   assign pix_active = ~x[10] & ~y[10];

   // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
   always_ff @(posedge clk) begin
      if (reset) begin
         divider     <= '0;
         pix_en      <= 1'b0;
         h_cnt       <= '0;
         v_cnt       <= '0;
         x           <= '0;
         y           <= '0;
         hs_q        <= 1'b0;
         vs_q        <= 1'b0;
         hsync       <= SYNC_OFF;
         vsync       <= SYNC_OFF;
         rgb_out     <= '0;
         frame_start <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         pix_en      <= (divider == DIV_LAST);
         divider     <= (divider == DIV_LAST) ? '0 : divider + DIV_W'(1);
         frame_start <= 1'b0;
         if (pix_en) begin
            h_cnt       <= h_next;
            v_cnt       <= v_next;
            x           <= {~h_act_next, h_next};
            y           <= {~v_act_next, v_next};
            hs_q        <= hs_next;
            vs_q        <= vs_next;
            // Colour and sync of the outgoing pixel leave together, one pixel behind x/y.
            hsync       <= hs_q ? SYNC_ON : SYNC_OFF;
            vsync       <= vs_q ? SYNC_ON : SYNC_OFF;
            rgb_out     <= pix_active ? rgb_in : 12'h000;
            frame_start <= h_wrap & v_wrap;
         end
      end
   end

`ifdef VGA_GEN_TICK_EN
   localparam int FC_W = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_GEN - 1);

   logic [FC_W-1:0] frame_cnt;

   // Counts frame starts; the wrap back to 0 is the generation step.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt <= '0;
         gen_tick  <= 1'b0;
      end else begin
         gen_tick <= 1'b0;
         if (pix_en && h_wrap && v_wrap) begin
            if (frame_cnt == FC_LAST) begin
               frame_cnt <= '0;
               gen_tick  <= 1'b1;
            end else begin
               frame_cnt <= frame_cnt + FC_W'(1);
            end
         end
      end
   end
`else
   assign gen_tick = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a closed-form raster model driven by
// elapsed clocks since reset, with random colour input and random mid-frame resets.
module tb_vga_timing_gen;

   localparam int D  = 3;
   localparam int HA = 8;
   localparam int HF = 2;
   localparam int HS = 3;
   localparam int HB = 2;
   localparam int VA = 6;
   localparam int VF = 1;
   localparam int VS = 2;
   localparam int VB = 1;
   localparam int NF = 3;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] rgb_in = 12'h000;
   logic        pix_en;
   logic [10:0] x;
   logic [10:0] y;
   logic        hsync;
   logic        vsync;
   logic [11:0] rgb_out;
   logic        frame_start;
   logic        gen_tick;

   int          vectors = 0;
   int          miscompares = 0;
   int          n = 0;
   logic [11:0] rgb_cap = 12'h000;

   vga_timing_gen #(
      .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_POL(1'b0), .FRAMES_PER_GEN(NF)
   ) dut (
      .clk(clk), .reset(reset), .rgb_in(rgb_in), .pix_en(pix_en),
      .x(x), .y(y), .hsync(hsync), .vsync(vsync), .rgb_out(rgb_out),
      .frame_start(frame_start), .gen_tick(gen_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s at clk %0d since reset: observed %h expected %h", tag, n, got, exp);
      end
   endtask

   // Expected outputs after n clocks out of reset, from the raster rules alone.
   task automatic check_outputs();
      int p, pp, h, v, hq, vq;
      logic        e_pix, e_hs, e_vs, e_fs, e_gt;
      logic [11:0] e_rgb;
      logic [10:0] e_x, e_y;
      p     = (n == 0) ? 0 : (n - 1) / D;
      pp    = p % FT;
      h     = pp % HT;
      v     = pp / HT;
      e_pix = (n >= D) && (n % D == 0);
      e_x   = {(h >= HA), 10'(h)};
      e_y   = {(v >= VA), 10'(v)};
      e_hs  = 1'b1;
      e_vs  = 1'b1;
      e_rgb = 12'h000;
      if (p >= 1) begin
         hq = ((p - 1) % FT) % HT;
         vq = ((p - 1) % FT) / HT;
         e_hs  = !((hq >= HA + HF) && (hq < HA + HF + HS));
         e_vs  = !((vq >= VA + VF) && (vq < VA + VF + VS));
         e_rgb = (hq < HA && vq < VA) ? rgb_cap : 12'h000;
      end
      e_fs = (n >= 1) && (n - 1 >= D) && ((n - 1) % D == 0) && (pp == 0);
`ifdef VGA_GEN_TICK_EN
      e_gt = e_fs && ((p / FT) % NF == 0);
`else
      e_gt = 1'b0;
`endif
      check("pix_en", {11'd0, pix_en}, {11'd0, e_pix});
      check("x", {1'b0, x}, {1'b0, e_x});
      check("y", {1'b0, y}, {1'b0, e_y});
      check("hsync", {11'd0, hsync}, {11'd0, e_hs});
      check("vsync", {11'd0, vsync}, {11'd0, e_vs});
      check("rgb_out", rgb_out, e_rgb);
      check("frame_start", {11'd0, frame_start}, {11'd0, e_fs});
      check("gen_tick", {11'd0, gen_tick}, {11'd0, e_gt});
   endtask

   // One clock: advance the model, drive new random colour, check on the falling edge.
   task automatic tick();
      logic [11:0] drv;
      logic        rst_at;
      drv    = rgb_in;
      rst_at = reset;
      @(posedge clk);
      if (rst_at) begin
         n = 0;
      end else begin
         n++;
         if ((n - 1 >= D) && ((n - 1) % D == 0)) rgb_cap = drv;
      end
      #1 rgb_in = 12'($urandom);
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      @(negedge clk);
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      repeat (2 * FT * D + 100) tick();
      for (int i = 0; i < 5; i++) begin
         repeat ($urandom_range(40, 400)) tick();
         reset = 1'b1;
         repeat ($urandom_range(1, 3)) tick();
         reset = 1'b0;
      end
      rgb_in = 12'hFFF;
      repeat (FT * D) begin
         rgb_in = 12'hFFF;
         tick();
      end
      repeat (NF * FT * D + 50) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
